// File: rtl/replenish_ctrl.sv
// replenish_ctrl: eight-channel stock controller with a restock FSM and a
// one-unit sale path.
//
// A restock request in IDLE latches a channel and a quantity. FILL then adds
// one unit per enabled cycle until the quantity is used up or the channel
// reaches CAP. DONE lasts one cycle and returns to IDLE. Sales are accepted
// in every state. All stock arithmetic saturates within 0..CAP.
//
// Parameters:
//   CAP        maximum units per channel (1..15)
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         enable; low freezes the FSM and blocks restock and sale requests
//   re         restock request (sampled in IDLE only)
//   number     channel to restock
//   qty        units requested for restock
//   sell       sale request (one unit)
//   sell_ch    channel for the sale
//   rd_ch      channel selected for stock_out
//   numbers    channel being filled (0 outside FILL)
//   busy       high in FILL and DONE
//   done       one-cycle pulse in DONE
//   sell_ack   pulse the cycle after an accepted sale
//   stock_out  stock count of rd_ch (combinational)
//   empty      bit i high when channel i holds no stock (combinational)
//   ovf        only with REPLENISH_OVERFLOW_ERR_EN defined: set in DONE when
//              a fill stopped at CAP with quantity left over; cleared on the
//              next accepted restock request or on rst
//
// Build option: define REPLENISH_OVERFLOW_ERR_EN to add the ovf output.
// Without it, the excess quantity is discarded silently.

module replenish_ctrl #(
    parameter int CAP = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       re,
    input  logic [2:0] number,
    input  logic [3:0] qty,
    input  logic       sell,
    input  logic [2:0] sell_ch,
    input  logic [2:0] rd_ch,
    output logic [2:0] numbers,
    output logic       busy,
    output logic       done,
    output logic       sell_ack,
    output logic [3:0] stock_out,
    output logic [7:0] empty
`ifdef REPLENISH_OVERFLOW_ERR_EN
    ,
    output logic       ovf
`endif
);

    localparam logic [3:0] CAP_V = 4'(CAP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    logic [2:0]      ch_reg;
    logic [3:0]      remaining_reg;
    logic [7:0][3:0] stock_vec;

    logic fill_end;
    logic fill_inc;
    logic sale_acc;

    // FILL stops, without incrementing, as soon as nothing is left to add or
    // the channel is already at capacity.
    assign fill_end = (remaining_reg == 4'd0) || (stock_vec[ch_reg] >= CAP_V);
    assign fill_inc = en && (state_reg == FILL) && !fill_end;

    // A sale looks at the stock before this cycle's fill increment, so a sale
    // on an empty channel is rejected even if that channel is being filled
    // in the same cycle.
    assign sale_acc = en && sell && (stock_vec[sell_ch] != 4'd0);

    assign stock_out = stock_vec[rd_ch];

    // Per-channel stock counters. When a fill and a sale hit the same channel
    // in the same cycle, they cancel. Each direction is guarded, so no count
    // goes below 0 or above CAP.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_chan
            logic [3:0] stock_reg;
            logic       inc;
            logic       dec;

            assign inc = fill_inc && (ch_reg == 3'(gi));
            assign dec = sale_acc && (sell_ch == 3'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stock_reg <= 4'd0;
                end else if (inc && !dec) begin
                    stock_reg <= stock_reg + 4'd1;
                end else if (dec && !inc) begin
                    stock_reg <= stock_reg - 4'd1;
                end
            end

            assign stock_vec[gi] = stock_reg;
            assign empty[gi]     = (stock_reg == 4'd0);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sell_ack <= 1'b0;
        end else begin
            sell_ack <= sale_acc;
        end
    end

    // Restock FSM. The outputs are registered and are loaded together with
    // the state, so each output always matches the state it belongs to.
    // With en low, everything holds, including a pending DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            ch_reg        <= 3'd0;
            remaining_reg <= 4'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            numbers       <= 3'd0;
        end else if (en) begin
            case (state_reg)
                IDLE: begin
                    if (re) begin
                        busy <= 1'b1;
                        if (qty != 4'd0) begin
                            state_reg     <= FILL;
                            ch_reg        <= number;
                            remaining_reg <= qty;
                            numbers       <= number;
                        end else begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (fill_end) begin
                        state_reg <= DONE;
                        done      <= 1'b1;
                        numbers   <= 3'd0;
                    end else begin
                        remaining_reg <= remaining_reg - 4'd1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    numbers   <= 3'd0;
                end
            endcase
        end
    end

`ifdef REPLENISH_OVERFLOW_ERR_EN
    // Flags a fill that stopped at CAP with quantity left over. The flag stays
    // set until the next accepted restock request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (en) begin
            if (state_reg == IDLE && re) begin
                ovf <= 1'b0;
            end else if (state_reg == FILL && fill_end) begin
                ovf <= (remaining_reg != 4'd0);
            end
        end
    end
`endif

endmodule
